// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared defaults and request/port types for the register-file writeback arbiter
package wb_arb_pkg;
    localparam int WB_NUM_REQ      = 3;
    localparam int WB_NUM_WP       = 2;
    localparam int WB_STARVE_LIMIT = 4;
    localparam int WB_CNT_W        = 3;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_port_t;
endpackage

// File: rtl/wb_prio_pick.sv
// wb_prio_pick: returns the first K set bits of a priority-ordered mask (bit 0 highest) as one-hot selections
module wb_prio_pick #(
    parameter int N = 6,
    parameter int K = 2
) (
    input  logic [N-1:0]        cand,
    output logic [K-1:0][N-1:0] sel
);
    logic [N-1:0] rem;

    always_comb begin
        rem = cand;
        for (int k = 0; k < K; k++) begin
            sel[k] = rem & (~rem + N'(1));
            rem    = rem & ~sel[k];
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: grants writeback requests onto registered RF write ports; WB_STALL_CNT_EN adds stall_cnt counters
module rf_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ      = WB_NUM_REQ,
    parameter int NUM_WP       = WB_NUM_WP,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0][4:0]  req_rd,
    input  logic [NUM_REQ-1:0][31:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_WP-1:0]        wp_we,
    output logic [NUM_WP-1:0][4:0]   wp_addr,
    output logic [NUM_WP-1:0][31:0]  wp_data
`ifdef WB_STALL_CNT_EN
    ,
    output logic [NUM_REQ-1:0][31:0] stall_cnt
`endif
);
    wb_req_t  [NUM_REQ-1:0]               req;
    logic     [NUM_REQ-1:0][WB_CNT_W-1:0] cnt_q, cnt_d;
    logic     [NUM_REQ-1:0]               promo, cand, grant;
    logic     [NUM_WP-1:0][2*NUM_REQ-1:0] pick;
    logic     [NUM_WP-1:0][NUM_REQ-1:0]   sel;
    wb_port_t [NUM_WP-1:0]                wp_q, wp_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]   = '{valid: req_valid[i], rd: req_rd[i], data: req_data[i]};
            promo[i] = cnt_q[i] == WB_CNT_W'(STARVE_LIMIT);
        end
    end

    // x0 writes need no port; a nonzero rd loses to any higher-priority valid request for the same rd
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = req[i].valid && req[i].rd != 5'd0;
            for (int j = 0; j < NUM_REQ; j++)
                if (j != i && req[j].valid && req[j].rd == req[i].rd &&
                    ((promo[j] && !promo[i]) || (promo[j] == promo[i] && j < i)))
                    cand[i] = 1'b0;
        end
    end

    // Low half holds promoted candidates, high half the rest, so promotion outranks fixed order
    wb_prio_pick #(
        .N(2*NUM_REQ),
        .K(NUM_WP)
    ) u_pick (
        .cand({cand & ~promo, cand & promo}),
        .sel (pick)
    );

    always_comb begin
        for (int w = 0; w < NUM_WP; w++) begin
            sel[w]  = pick[w][NUM_REQ-1:0] | pick[w][2*NUM_REQ-1:NUM_REQ];
            wp_d[w] = '{we: 1'b0, addr: wp_q[w].addr, data: wp_q[w].data};
            for (int i = 0; i < NUM_REQ; i++)
                if (sel[w][i])
                    wp_d[w] = '{we: 1'b1, addr: req[i].rd, data: req[i].data};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = req[i].valid && req[i].rd == 5'd0;
            for (int w = 0; w < NUM_WP; w++)
                grant[i] = grant[i] | sel[w][i];
            cnt_d[i] = (!req[i].valid || grant[i]) ? '0 :
                       promo[i] ? cnt_q[i] : cnt_q[i] + WB_CNT_W'(1);
        end
    end

    assign req_ready = grant & {NUM_REQ{rst}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            wp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WP; w++) begin
            wp_we[w]   = wp_q[w].we;
            wp_addr[w] = wp_q[w].addr;
            wp_data[w] = wp_q[w].data;
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [NUM_REQ-1:0][31:0] stall_q, stall_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            stall_d[i] = stall_q[i] + 32'(req[i].valid && !grant[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter with default parameters
module tb_rf_wb_arbiter;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_rd;
    logic [2:0][31:0] req_data;
    logic [2:0]       req_ready;
    logic [1:0]       wp_we;
    logic [1:0][4:0]  wp_addr;
    logic [1:0][31:0] wp_data;
`ifdef WB_STALL_CNT_EN
    logic [2:0][31:0] stall_cnt;
`endif

    typedef struct {
        logic [1:0]       we;
        logic [1:0][4:0]  addr;
        logic [1:0][31:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]       v;
        logic [2:0][4:0]  rd;
        logic [2:0][31:0] d;
        logic [2:0]       er;
        logic [1:0]       ewe;
        logic [1:0][4:0]  ea;
        logic [1:0][31:0] ed;
    } vec_t;

    exp_t             q[$];
    logic [1:0][4:0]  last_addr;
    logic [1:0][31:0] last_data;
    int               n_checks = 0;
    int               n_fail = 0;

    rf_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rd   (req_rd),
        .req_data (req_data),
        .req_ready(req_ready),
        .wp_we    (wp_we),
        .wp_addr  (wp_addr),
        .wp_data  (wp_data)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [2:0] v, input logic [4:0] r0, r1, r2,
                                input logic [31:0] d0, d1, d2, input logic [2:0] er,
                                input logic [1:0] ewe, input logic [4:0] a0,
                                input logic [31:0] e0, input logic [4:0] a1,
                                input logic [31:0] e1);
        vec_t t;
        t.v   = v;
        t.rd  = {r2, r1, r0};
        t.d   = {d2, d1, d0};
        t.er  = er;
        t.ewe = ewe;
        t.ea  = {a1, a0};
        t.ed  = {e1, e0};
        return t;
    endfunction

    task automatic push_exp(input vec_t t);
        exp_t e;
        e.we = t.ewe;
        for (int w = 0; w < 2; w++) begin
            e.addr[w] = t.ewe[w] ? t.ea[w] : last_addr[w];
            e.data[w] = t.ewe[w] ? t.ed[w] : last_data[w];
        end
        last_addr = e.addr;
        last_data = e.data;
        q.push_back(e);
    endtask

    task automatic advance(output exp_t e);
        @(posedge clk);
        #1;
        e = q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 3'b111;
        req_rd = {5'd3, 5'd2, 5'd1};
        req_data = '1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset ready got %b want 000", req_ready); end
        n_checks++;
        if (wp_we !== 2'b00) begin n_fail++; $display("FAIL reset wp_we got %b want 00", wp_we); end
        n_checks++;
        if (wp_addr !== '0) begin n_fail++; $display("FAIL reset wp_addr got %h want 0", wp_addr); end
        n_checks++;
        if (wp_data !== '0) begin n_fail++; $display("FAIL reset wp_data got %h want 0", wp_data); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (wp_we !== 2'b00) begin n_fail++; $display("FAIL reset_release wp_we got %b want 00", wp_we); end
    endtask

`ifdef WB_STALL_CNT_EN
    task automatic test_stall_cnt();
        vec_t vs[$];
        exp_t g;
        vs.push_back(mk(3'b111, 5'd11, 5'd12, 5'd13, 32'h11, 32'h12, 32'h13, 3'b011, 2'b11, 5'd11, 32'h11, 5'd12, 32'h12));
        vs.push_back(mk(3'b111, 5'd14, 5'd15, 5'd13, 32'h14, 32'h15, 32'h13, 3'b011, 2'b11, 5'd14, 32'h14, 5'd15, 32'h15));
        vs.push_back(mk(3'b111, 5'd16, 5'd17, 5'd13, 32'h16, 32'h17, 32'h13, 3'b011, 2'b11, 5'd16, 32'h16, 5'd17, 32'h17));
        vs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0));
        foreach (vs[c]) begin
            req_valid = vs[c].v; req_rd = vs[c].rd; req_data = vs[c].d;
            #1;
            n_checks++;
            if (req_ready !== vs[c].er) begin n_fail++; $display("FAIL stall[%0d] ready got %b want %b", c, req_ready, vs[c].er); end
            push_exp(vs[c]);
            advance(g);
            n_checks++;
            if (wp_we !== g.we) begin n_fail++; $display("FAIL stall[%0d] wp_we got %b want %b", c, wp_we, g.we); end
        end
        n_checks++;
        if (stall_cnt !== {32'd3, 32'd0, 32'd0})
            begin n_fail++; $display("FAIL stall_cnt got %h want %h", stall_cnt, {32'd3, 32'd0, 32'd0}); end
    endtask
`endif

    task automatic test_basic();
        vec_t vs[$];
        exp_t g;
        vs.push_back(mk(3'b111, 5'd5, 5'd6, 5'd7, 32'hA000_0005, 32'hA100_0006, 32'hA200_0007, 3'b011, 2'b11, 5'd5, 32'hA000_0005, 5'd6, 32'hA100_0006));
        vs.push_back(mk(3'b100, 5'd5, 5'd6, 5'd7, 32'hA000_0005, 32'hA100_0006, 32'hA200_0007, 3'b100, 2'b01, 5'd7, 32'hA200_0007, 5'd0, 32'h0));
        vs.push_back(mk(3'b000, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0));
        foreach (vs[c]) begin
            req_valid = vs[c].v; req_rd = vs[c].rd; req_data = vs[c].d;
            #1;
            n_checks++;
            if (req_ready !== vs[c].er) begin n_fail++; $display("FAIL basic[%0d] ready got %b want %b", c, req_ready, vs[c].er); end
            push_exp(vs[c]);
            advance(g);
            n_checks++;
            if (wp_we !== g.we) begin n_fail++; $display("FAIL basic[%0d] wp_we got %b want %b", c, wp_we, g.we); end
            n_checks++;
            if (wp_addr !== g.addr) begin n_fail++; $display("FAIL basic[%0d] wp_addr got %h want %h", c, wp_addr, g.addr); end
            n_checks++;
            if (wp_data !== g.data) begin n_fail++; $display("FAIL basic[%0d] wp_data got %h want %h", c, wp_data, g.data); end
        end
    endtask

    task automatic test_conflict();
        vec_t vs[$];
        exp_t g;
        vs.push_back(mk(3'b011, 5'd9, 5'd9, 5'd0, 32'h9000_0000, 32'h9000_0001, 32'h0, 3'b001, 2'b01, 5'd9, 32'h9000_0000, 5'd0, 32'h0));
        vs.push_back(mk(3'b010, 5'd9, 5'd9, 5'd0, 32'h9000_0000, 32'h9000_0001, 32'h0, 3'b010, 2'b01, 5'd9, 32'h9000_0001, 5'd0, 32'h0));
        vs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0));
        foreach (vs[c]) begin
            req_valid = vs[c].v; req_rd = vs[c].rd; req_data = vs[c].d;
            #1;
            n_checks++;
            if (req_ready !== vs[c].er) begin n_fail++; $display("FAIL conflict[%0d] ready got %b want %b", c, req_ready, vs[c].er); end
            push_exp(vs[c]);
            advance(g);
            n_checks++;
            if (wp_we !== g.we) begin n_fail++; $display("FAIL conflict[%0d] wp_we got %b want %b", c, wp_we, g.we); end
            n_checks++;
            if (wp_addr !== g.addr) begin n_fail++; $display("FAIL conflict[%0d] wp_addr got %h want %h", c, wp_addr, g.addr); end
            n_checks++;
            if (wp_data !== g.data) begin n_fail++; $display("FAIL conflict[%0d] wp_data got %h want %h", c, wp_data, g.data); end
        end
    endtask

    task automatic test_x0();
        vec_t vs[$];
        exp_t g;
        vs.push_back(mk(3'b111, 5'd3, 5'd0, 5'd4, 32'h0000_0003, 32'h0000_DEAD, 32'h0000_0004, 3'b111, 2'b11, 5'd3, 32'h0000_0003, 5'd4, 32'h0000_0004));
        vs.push_back(mk(3'b111, 5'd0, 5'd0, 5'd0, 32'h1, 32'h2, 32'h3, 3'b111, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0));
        vs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0));
        foreach (vs[c]) begin
            req_valid = vs[c].v; req_rd = vs[c].rd; req_data = vs[c].d;
            #1;
            n_checks++;
            if (req_ready !== vs[c].er) begin n_fail++; $display("FAIL x0[%0d] ready got %b want %b", c, req_ready, vs[c].er); end
            push_exp(vs[c]);
            advance(g);
            n_checks++;
            if (wp_we !== g.we) begin n_fail++; $display("FAIL x0[%0d] wp_we got %b want %b", c, wp_we, g.we); end
            n_checks++;
            if (wp_addr !== g.addr) begin n_fail++; $display("FAIL x0[%0d] wp_addr got %h want %h", c, wp_addr, g.addr); end
            n_checks++;
            if (wp_data !== g.data) begin n_fail++; $display("FAIL x0[%0d] wp_data got %h want %h", c, wp_data, g.data); end
        end
    endtask

    task automatic test_starve();
        vec_t vs[$];
        exp_t g;
        for (int c = 0; c < 4; c++)
            vs.push_back(mk(3'b111, 5'(8 + c), 5'(13 + c), 5'd20,
                            32'h1000_0000 + 32'(c), 32'h2000_0000 + 32'(c), 32'h3000_0020,
                            3'b011, 2'b11, 5'(8 + c), 32'h1000_0000 + 32'(c),
                            5'(13 + c), 32'h2000_0000 + 32'(c)));
        vs.push_back(mk(3'b111, 5'd12, 5'd17, 5'd20, 32'h1000_0004, 32'h2000_0004, 32'h3000_0020,
                        3'b101, 2'b11, 5'd20, 32'h3000_0020, 5'd12, 32'h1000_0004));
        vs.push_back(mk(3'b011, 5'd21, 5'd17, 5'd20, 32'h1000_0005, 32'h2000_0004, 32'h3000_0020,
                        3'b011, 2'b11, 5'd21, 32'h1000_0005, 5'd17, 32'h2000_0004));
        vs.push_back(mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0));
        foreach (vs[c]) begin
            req_valid = vs[c].v; req_rd = vs[c].rd; req_data = vs[c].d;
            #1;
            n_checks++;
            if (req_ready !== vs[c].er) begin n_fail++; $display("FAIL starve[%0d] ready got %b want %b", c, req_ready, vs[c].er); end
            push_exp(vs[c]);
            advance(g);
            n_checks++;
            if (wp_we !== g.we) begin n_fail++; $display("FAIL starve[%0d] wp_we got %b want %b", c, wp_we, g.we); end
            n_checks++;
            if (wp_addr !== g.addr) begin n_fail++; $display("FAIL starve[%0d] wp_addr got %h want %h", c, wp_addr, g.addr); end
            n_checks++;
            if (wp_data !== g.data) begin n_fail++; $display("FAIL starve[%0d] wp_data got %h want %h", c, wp_data, g.data); end
        end
    endtask

    // Requester 2 builds up a wait count of 3 before reset; after reset it must wait the full limit again
    task automatic test_reset_mid();
        vec_t vs[$];
        exp_t g;
        for (int c = 0; c < 3; c++)
            vs.push_back(mk(3'b111, 5'(1 + c), 5'(4 + c), 5'd30,
                            32'h4000_0000 + 32'(c), 32'h5000_0000 + 32'(c), 32'h6000_0030,
                            3'b011, 2'b11, 5'(1 + c), 32'h4000_0000 + 32'(c),
                            5'(4 + c), 32'h5000_0000 + 32'(c)));
        foreach (vs[c]) begin
            req_valid = vs[c].v; req_rd = vs[c].rd; req_data = vs[c].d;
            #1;
            n_checks++;
            if (req_ready !== vs[c].er) begin n_fail++; $display("FAIL rstmid[%0d] ready got %b want %b", c, req_ready, vs[c].er); end
            push_exp(vs[c]);
            advance(g);
            n_checks++;
            if (wp_we !== g.we) begin n_fail++; $display("FAIL rstmid[%0d] wp_we got %b want %b", c, wp_we, g.we); end
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (wp_we !== 2'b00) begin n_fail++; $display("FAIL rstmid async wp_we got %b want 00", wp_we); end
        n_checks++;
        if (wp_addr !== '0) begin n_fail++; $display("FAIL rstmid async wp_addr got %h want 0", wp_addr); end
        n_checks++;
        if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rstmid ready got %b want 000", req_ready); end
        last_addr = '0;
        last_data = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (wp_we !== 2'b00) begin n_fail++; $display("FAIL rstmid held wp_we got %b want 00", wp_we); end
        rst = 1'b1;
        test_starve();
    endtask

    initial begin
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        last_addr = '0;
        last_data = '0;
        test_reset();
`ifdef WB_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_basic();
        test_conflict();
        test_x0();
        test_starve();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
